// File: rtl/als_spi_reader.sv
// SPI master for the PmodALS light sensor (ADC081S021): periodic 16-SCLK read frames,
// 8-bit light value extracted and presented as a 16-bit display word.
module als_spi_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 2_500_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        miso,
  input  logic        hold,
  output logic        cs_n,
  output logic        sclk,
  output logic [7:0]  light,
  output logic [15:0] data,
  output logic        valid
);

  localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   period;
  logic [DW-1:0]   div, div_n;
  logic [3:0]      bit_cnt, bit_n;
  logic            hi, hi_n;
  // The three leading zeros shift out of the top; [12:5] lands on D7..D0 after 16 samples.
  logic [12:0]     shift, shift_n;
  logic            div_last;
  logic            cs_n_n, sclk_n;

  // Free-running frame-rate counter
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) period <= '0;
    else if (period == PW'(SAMPLE_PERIOD - 1)) period <= '0;
    else period <= period + PW'(1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      hi      <= 1'b0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= bit_n;
      hi      <= hi_n;
      shift   <= shift_n;
    end
  end

  assign div_last = (div == DW'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_cnt;
    hi_n    = hi;
    shift_n = shift;
    case (state)
      IDLE: begin
        if (period == '0) begin
          state_n = SETUP;
          div_n   = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_n = SHIFT;
          div_n   = '0;
          hi_n    = 1'b0;
          bit_n   = '0;
        end else begin
          div_n = div + DW'(1);
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_n = '0;
          if (!hi) begin
            // Low half ends: sclk rises on this edge, so sample here
            hi_n    = 1'b1;
            shift_n = {shift[11:0], miso};
          end else if (bit_cnt == 4'd15) begin
            state_n = DONE;
          end else begin
            hi_n  = 1'b0;
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cs_n_n = (state_n == IDLE) || (state_n == DONE);
    sclk_n = !((state_n == SHIFT) && !hi_n);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cs_n  <= 1'b1;
      sclk  <= 1'b1;
      light <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      cs_n  <= cs_n_n;
      sclk  <= sclk_n;
      valid <= (state == DONE) && !hold;
      if ((state == DONE) && !hold) begin
        light <= shift[12:5];
        data  <= {8'h00, shift[12:5]};
      end
    end
  end

endmodule

// File: tb/tb_als_spi_reader.sv
// Directed bench for als_spi_reader with a behavioural ADC081S021 model on miso.
module tb_als_spi_reader;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned SP      = 400;

  logic        clk_in, reset, miso, hold;
  logic        cs_n, sclk, valid;
  logic [7:0]  light;
  logic [15:0] data;

  logic [15:0] adc_word;
  int          idx;
  int          cyc;
  int          rise_cnt, fall_cnt, cs_low;
  int          errors, checks;
  int          cyc0, at, at_prev;
  bit          seen;

  als_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP)) dut (
    .clk_in(clk_in), .reset(reset), .miso(miso), .hold(hold),
    .cs_n(cs_n), .sclk(sclk), .light(light), .data(data), .valid(valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // ADC model: shifts out MSB first, updating on each falling sclk
  always @(negedge cs_n) begin
    idx = 15;
    rise_cnt = 0;
    fall_cnt = 0;
  end
  always @(negedge sclk) begin
    if (!cs_n) begin
      fall_cnt = fall_cnt + 1;
      if (idx >= 0) begin
        miso = adc_word[idx];
        idx = idx - 1;
      end
    end
  end
  always @(posedge sclk) if (!cs_n) rise_cnt = rise_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output bit got, output int when);
    got  = 1'b0;
    when = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_in);
      #1;
      if (!cs_n) cs_low++;
      if (valid) begin
        got  = 1'b1;
        when = cyc;
        break;
      end
    end
  endtask

  function automatic logic [15:0] frame(input logic [7:0] v);
    return {3'b000, v, 5'b00000};
  endfunction

  initial begin
    cyc = 0; errors = 0; checks = 0; idx = 15;
    rise_cnt = 0; fall_cnt = 0; cs_low = 0;
    reset = 1'b1; hold = 1'b0; miso = 1'b0;
    adc_word = frame(8'hA5);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_light", 32'(light), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);

    // Single frame 0xA5: first frame starts on the first edge after release
    @(negedge clk_in);
    reset = 1'b0;
    cyc0 = cyc;
    cs_low = 0;
    wait_valid(2 * SP, seen, at);
    chk("f1_seen", 32'(seen), 32'd1);
    chk("f1_latency", 32'(at - cyc0 - 1), 32'd133);
    chk("f1_light", 32'(light), 32'hA5);
    chk("f1_data", 32'(data), 32'h00A5);
    chk("f1_rises", 32'(rise_cnt), 32'd16);
    chk("f1_falls", 32'(fall_cnt), 32'd16);
    chk("f1_cs_low", 32'(cs_low), 32'd132);
    @(posedge clk_in);
    #1;
    chk("f1_pulse_1cyc", 32'(valid), 32'd0);
    chk("f1_cs_idle", 32'(cs_n), 32'd1);
    at_prev = at;

    // Periodic frames 0x00 then 0xFF
    adc_word = frame(8'h00);
    wait_valid(2 * SP, seen, at);
    chk("p0_seen", 32'(seen), 32'd1);
    chk("p0_gap", 32'(at - at_prev), 32'd400);
    chk("p0_data", 32'(data), 32'h0000);
    at_prev = at;
    adc_word = frame(8'hFF);
    wait_valid(2 * SP, seen, at);
    chk("pf_gap", 32'(at - at_prev), 32'd400);
    chk("pf_data", 32'(data), 32'h00FF);
    chk("pf_light", 32'(light), 32'hFF);

    // Hold: 0xA5 captured, then 0x3C frame frozen out, then released
    adc_word = frame(8'hA5);
    wait_valid(2 * SP, seen, at);
    chk("h_pre_data", 32'(data), 32'h00A5);
    adc_word = frame(8'h3C);
    hold = 1'b1;
    wait_valid(SP + 20, seen, at);
    chk("h_no_valid", 32'(seen), 32'd0);
    chk("h_frozen", 32'(data), 32'h00A5);
    hold = 1'b0;
    wait_valid(2 * SP, seen, at);
    chk("h_rel_seen", 32'(seen), 32'd1);
    chk("h_rel_data", 32'(data), 32'h003C);

    // Reset at the 8th rising sclk of a 0x77 frame
    adc_word = frame(8'h77);
    seen = 1'b0;
    for (int i = 0; i < 2 * SP; i++) begin
      @(posedge clk_in);
      #1;
      if (!cs_n && rise_cnt >= 8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("r_reach8", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    chk("r_cs_n", 32'(cs_n), 32'd1);
    chk("r_sclk", 32'(sclk), 32'd1);
    chk("r_light", 32'(light), 32'h0);
    chk("r_data", 32'(data), 32'h0);
    chk("r_valid", 32'(valid), 32'd0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    cyc0 = cyc;
    wait_valid(50, seen, at);
    chk("r_no_early_valid", 32'(seen), 32'd0);
    chk("r_light_still0", 32'(light), 32'h0);
    wait_valid(2 * SP, seen, at);
    chk("r_new_latency", 32'(at - cyc0 - 1), 32'd133);
    chk("r_new_light", 32'(light), 32'h77);

    // Junk in framing bits must be ignored
    adc_word = {3'b111, 8'h5A, 5'b11111};
    wait_valid(2 * SP, seen, at);
    chk("j_seen", 32'(seen), 32'd1);
    chk("j_light", 32'(light), 32'h5A);
    chk("j_data", 32'(data), 32'h005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
